// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package core_sequencer_pkg;

   localparam int unsigned INSTR_WIDTH = 32;
   localparam int unsigned CAUSE_WIDTH = 2;

   typedef enum logic [2:0] {
      RESET_S,
      FETCH,
      DECODE,
      EXECUTE,
      MEM,
      WRITEBACK,
      TRAP
   } seqState_t;

   typedef enum logic [CAUSE_WIDTH-1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_ILLEGAL    = 2'd1,
      CAUSE_MISALIGNED = 2'd2,
      CAUSE_TIMEOUT    = 2'd3
   } trapCause_t;

   // addi x0, x0, 0
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Saturating wait counter; hit flags the cycle in which an enabled count reaches LIMIT.
module core_sequencer_wait_timer #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int unsigned CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
   localparam logic [CW-1:0] MAX  = CW'(LIMIT);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != MAX)) begin
         count <= count + CW'(1);
      end
   end

   // Look-ahead: this enabled cycle is the LIMIT-th one spent waiting.
   assign hit = en & (count >= LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: owns PC and instruction register, steps FETCH..WRITEBACK over
// handshaked memories, and traps on illegal opcodes, misaligned branches and memory timeouts.
module core_sequencer
   import core_sequencer_pkg::*;
#(
   parameter int unsigned REG_DATA_WIDTH_POW = 6,
   parameter logic [63:0] RESET_PC           = 64'h0,
   parameter int unsigned MEM_TIMEOUT        = 255,
   localparam int unsigned W                 = 1 << REG_DATA_WIDTH_POW
) (
   input  logic                   clk_in,
   input  logic                   reset,
   output logic                   imem_req_out,
   output logic [W-1:0]           imem_addr_out,
   input  logic                   imem_valid_in,
   input  logic [INSTR_WIDTH-1:0] imem_instr_in,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [W-1:0]           pc_out,
   input  logic                   illegal_in,
   input  logic                   memRead_in,
   input  logic                   memWrite_in,
   input  logic                   regWrite_in,
   input  logic                   branchCtrl_in,
   input  logic                   zeroFlag_in,
   input  logic [W-1:0]           branchTarget_in,
   output logic                   dmem_req_out,
   output logic                   dmem_we_out,
   input  logic                   dmem_valid_in,
   output logic                   regWrite_out,
   output logic                   retire_out,
   output logic                   trap_out,
   output logic [CAUSE_WIDTH-1:0] trapCause_out
);

   seqState_t              state, state_d;
   trapCause_t             cause_q, cause_d;
   logic [W-1:0]           pc_d;
   logic [INSTR_WIDTH-1:0] instr_d;
   logic                   trap_d;
   logic                   taken, misaligned;
   logic                   timer_en, timer_clr, timer_hit;

   assign taken         = branchCtrl_in & zeroFlag_in;
   assign misaligned    = |branchTarget_in[1:0];
   assign imem_addr_out = pc_out;
   assign trapCause_out = cause_q;

   // Waiting means sitting in a memory state with no response this cycle.
   assign timer_en  = ((state == FETCH) & ~imem_valid_in) | ((state == MEM) & ~dmem_valid_in);
   assign timer_clr = (state_d != state);

   core_sequencer_wait_timer #(
      .LIMIT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk  (clk_in),
      .rst_n(reset),
      .clr  (timer_clr),
      .en   (timer_en),
      .hit  (timer_hit)
   );

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state     <= RESET_S;
         pc_out    <= W'(RESET_PC);
         instr_out <= NOP_INSTR;
         trap_out  <= 1'b0;
         cause_q   <= CAUSE_NONE;
      end else begin
         state     <= state_d;
         pc_out    <= pc_d;
         instr_out <= instr_d;
         trap_out  <= trap_d;
         cause_q   <= cause_d;
      end
   end

   always_comb begin
      state_d      = state;
      pc_d         = pc_out;
      instr_d      = instr_out;
      trap_d       = trap_out;
      cause_d      = cause_q;
      imem_req_out = 1'b0;
      dmem_req_out = 1'b0;
      dmem_we_out  = 1'b0;
      regWrite_out = 1'b0;
      retire_out   = 1'b0;

      case (state)
         RESET_S: state_d = FETCH;
         FETCH: begin
            imem_req_out = 1'b1;
            if (imem_valid_in) begin
               instr_d = imem_instr_in;
               state_d = DECODE;
            end else if (timer_hit) begin
               state_d = TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         DECODE: begin
            if (illegal_in) begin
               state_d = TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = EXECUTE;
            end
         end
         EXECUTE: state_d = (memRead_in | memWrite_in) ? MEM : WRITEBACK;
         MEM: begin
            // A combined read+write request is treated as a write.
            dmem_req_out = 1'b1;
            dmem_we_out  = memWrite_in;
            if (dmem_valid_in) begin
               state_d = WRITEBACK;
            end else if (timer_hit) begin
               state_d = TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         WRITEBACK: begin
            if (taken && misaligned) begin
               state_d = TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_MISALIGNED;
            end else begin
               state_d      = FETCH;
               retire_out   = 1'b1;
               regWrite_out = regWrite_in;
               pc_d         = taken ? branchTarget_in : pc_out + W'(4);
            end
         end
         TRAP: state_d = TRAP;
         default: state_d = RESET_S;
      endcase
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: vector table, hand-written reset/trap sequences, random run vs model.
module tb_core_sequencer;
   import core_sequencer_pkg::*;

   localparam int TO = 4;

   logic        clk_in = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req_out, imem_valid_in = 1'b0;
   logic [63:0] imem_addr_out;
   logic [31:0] imem_instr_in = '0, instr_out;
   logic [63:0] pc_out, branchTarget_in = '0;
   logic        illegal_in = 1'b0, memRead_in = 1'b0, memWrite_in = 1'b0;
   logic        regWrite_in = 1'b0, branchCtrl_in = 1'b0, zeroFlag_in = 1'b0;
   logic        dmem_req_out, dmem_we_out, dmem_valid_in = 1'b0;
   logic        regWrite_out, retire_out, trap_out;
   logic [1:0]  trapCause_out;

   core_sequencer #(
      .REG_DATA_WIDTH_POW(6),
      .RESET_PC          (64'h0),
      .MEM_TIMEOUT       (TO)
   ) dut (
      .clk_in(clk_in), .reset(reset),
      .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
      .imem_valid_in(imem_valid_in), .imem_instr_in(imem_instr_in),
      .instr_out(instr_out), .pc_out(pc_out),
      .illegal_in(illegal_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
      .regWrite_in(regWrite_in), .branchCtrl_in(branchCtrl_in), .zeroFlag_in(zeroFlag_in),
      .branchTarget_in(branchTarget_in),
      .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_valid_in(dmem_valid_in),
      .regWrite_out(regWrite_out), .retire_out(retire_out),
      .trap_out(trap_out), .trapCause_out(trapCause_out)
   );

   always #5 clk_in = ~clk_in;

   // One instruction: memory delays, control bits, and expected outcome.
   typedef struct {
      int          idly, ddly;
      bit          rd, wr, rw, br, zf, ill;
      logic [63:0] tgt;
      int          lat;
      bit          ret;
      int          cause, dreq;
      logic [63:0] npc;
   } vec_t;

   int          n_pass = 0, n_total = 0;
   logic [63:0] model_pc = '0;
   bit          trapped_last = 1'b0;
   bit          stray_en = 1'b0;
   vec_t        tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input int idly, input int ddly, input int rd, input int wr,
                               input int rw, input int br, input int zf, input int ill,
                               input logic [63:0] tgt, input int lat, input int ret,
                               input int cause, input int dreq, input logic [63:0] npc);
      vec_t v;
      v.idly = idly; v.ddly = ddly;
      v.rd = (rd != 0); v.wr = (wr != 0); v.rw = (rw != 0);
      v.br = (br != 0); v.zf = (zf != 0); v.ill = (ill != 0);
      v.tgt = tgt; v.lat = lat; v.ret = (ret != 0);
      v.cause = cause; v.dreq = dreq; v.npc = npc;
      return v;
   endfunction

   // Outcome from the per-instruction timing rules; lat is the cycle (from FETCH entry)
   // on which retire is seen, or on which trap_out first reads high.
   function automatic void model(inout vec_t v, input logic [63:0] pc);
      bit mem = v.rd || v.wr;
      v.npc = pc; v.ret = 1'b0; v.cause = 0; v.dreq = 0;
      if (v.idly >= TO) begin
         v.lat = TO + 1; v.cause = 3;
      end else if (v.ill) begin
         v.lat = v.idly + 3; v.cause = 1;
      end else if (mem && v.ddly >= TO) begin
         v.dreq = TO; v.lat = v.idly + 4 + TO; v.cause = 3;
      end else begin
         v.dreq = mem ? v.ddly + 1 : 0;
         v.lat  = v.idly + 4 + v.dreq;
         if (v.br && v.zf && v.tgt[1:0] != 2'b00) begin
            v.lat = v.lat + 1; v.cause = 2;
         end else begin
            v.ret = 1'b1;
            v.npc = (v.br && v.zf) ? v.tgt : pc + 64'd4;
         end
      end
   endfunction

   task automatic do_reset(input bit check);
      reset = 1'b0; imem_valid_in = 1'b0; dmem_valid_in = 1'b0;
      regWrite_in = 1'b1; memWrite_in = 1'b1;
      @(posedge clk_in); #1;
      if (check) begin
         chk("rst pc", pc_out, 64'h0);
         chk("rst instr", 64'(instr_out), 64'h13);
         chk("rst imem_req", 64'(imem_req_out), 64'h0);
         chk("rst dmem_req", 64'(dmem_req_out), 64'h0);
         chk("rst dmem_we", 64'(dmem_we_out), 64'h0);
         chk("rst regWrite", 64'(regWrite_out), 64'h0);
         chk("rst retire", 64'(retire_out), 64'h0);
         chk("rst trap", 64'(trap_out), 64'h0);
         chk("rst cause", 64'(trapCause_out), 64'h0);
      end
      reset = 1'b1;
      @(posedge clk_in); #1;
      model_pc = '0;
      trapped_last = 1'b0;
   endtask

   // Pokes both valids while trapped; nothing may change.
   task automatic poke_trap(input int cause);
      imem_valid_in = 1'b1; dmem_valid_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      chk("trap held", 64'(trap_out), 64'h1);
      chk("trap cause held", 64'(trapCause_out), 64'(cause));
      chk("trap pc held", pc_out, model_pc);
      chk("trap no req", 64'({imem_req_out, dmem_req_out, retire_out}), 64'h0);
      imem_valid_in = 1'b0; dmem_valid_in = 1'b0;
   endtask

   // Entered at posedge+1 of a FETCH cycle; acts as both memories for one instruction.
   task automatic run_instr(input vec_t v, input string tag);
      logic [31:0] word = $urandom();
      int cyc = 0, iw = 0, dw = 0, dreq_n = 0, ret_n = 0, rw_n = 0, bad_addr = 0, bad_we = 0;
      bit done = 1'b0, trapped = 1'b0;
      illegal_in = v.ill; memRead_in = v.rd; memWrite_in = v.wr; regWrite_in = v.rw;
      branchCtrl_in = v.br; zeroFlag_in = v.zf; branchTarget_in = v.tgt; imem_instr_in = word;
      chk({tag, " fetch_addr"}, imem_addr_out, model_pc);
      while (!done) begin
         cyc++;
         if (trap_out) begin
            trapped = 1'b1; done = 1'b1;
         end else begin
            if (imem_req_out) begin
               imem_valid_in = (iw == v.idly); iw++;
               if (imem_addr_out !== model_pc) bad_addr++;
            end else imem_valid_in = stray_en && ($urandom_range(3) == 0);
            if (dmem_req_out) begin
               dmem_valid_in = (dw == v.ddly); dw++; dreq_n++;
               if (dmem_we_out !== v.wr) bad_we++;
            end else dmem_valid_in = stray_en && ($urandom_range(3) == 0);
            @(negedge clk_in);
            if (regWrite_out) rw_n++;
            if (retire_out) begin ret_n++; done = 1'b1; end
            if (!done && cyc >= 200) begin
               chk({tag, " cycle budget"}, 64'(cyc), 64'(v.lat)); done = 1'b1;
            end
            @(posedge clk_in); #1;
         end
      end
      imem_valid_in = 1'b0; dmem_valid_in = 1'b0;
      chk({tag, " latency"}, 64'(cyc), 64'(v.lat));
      chk({tag, " retire"}, 64'(ret_n), 64'(v.ret));
      chk({tag, " regWrite"}, 64'(rw_n), 64'(v.ret && v.rw));
      chk({tag, " dmem_req cycles"}, 64'(dreq_n), 64'(v.dreq));
      chk({tag, " bad dmem_we"}, 64'(bad_we), 64'h0);
      chk({tag, " bad imem_addr"}, 64'(bad_addr), 64'h0);
      chk({tag, " trap"}, 64'(trap_out), 64'(v.cause != 0));
      chk({tag, " cause"}, 64'(trapCause_out), 64'(v.cause));
      chk({tag, " pc"}, pc_out, v.npc);
      if (v.idly < TO) chk({tag, " instr"}, 64'(instr_out), 64'(word));
      if (trapped) chk({tag, " trap reqs"}, 64'({imem_req_out, dmem_req_out}), 64'h0);
      model_pc = v.npc;
      trapped_last = trapped;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      // idly ddly rd wr rw br zf ill tgt | lat ret cause dreq npc
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 64'h0,  4, 1, 0, 0, 64'h4));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 64'h0,  4, 1, 0, 0, 64'h8));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 64'h0,  4, 1, 0, 0, 64'hC));
      tbl.push_back(mk(0, 3, 1, 0, 1, 0, 0, 0, 64'h0,  8, 1, 0, 4, 64'h10));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 64'h0,  5, 1, 0, 1, 64'h14));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 64'h0,  6, 1, 0, 2, 64'h18));
      tbl.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 64'h0,  6, 1, 0, 0, 64'h1C));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 64'h80, 4, 1, 0, 0, 64'h20));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 64'h80, 4, 1, 0, 0, 64'h24));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 64'h40, 4, 1, 0, 0, 64'h40));
      tbl.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 64'h0,  7, 1, 0, 0, 64'h44));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 64'h42, 5, 0, 2, 0, 64'h44));
      tbl.push_back(mk(9, 0, 0, 0, 1, 0, 0, 0, 64'h0,  5, 0, 3, 0, 64'h0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 64'h0,  4, 0, 1, 0, 64'h0));
      tbl.push_back(mk(0, 4, 1, 0, 1, 0, 0, 0, 64'h0,  8, 0, 3, 4, 64'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC,
                       4, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 64'h0,  4, 1, 0, 0, 64'h0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 64'h41, 6, 0, 2, 1, 64'h0));

      do_reset(1'b1);
      foreach (tbl[i]) begin
         if (trapped_last) begin
            poke_trap(tbl[i-1].cause);
            do_reset(1'b0);
         end
         run_instr(tbl[i], $sformatf("vec%0d", i));
      end
      if (trapped_last) poke_trap(tbl[tbl.size()-1].cause);

      // Reset asserted in the middle of a data access.
      do_reset(1'b0);
      run_instr(mk(0, 0, 0, 0, 1, 0, 0, 0, 64'h0, 4, 1, 0, 0, 64'h4), "pre_mem");
      memRead_in = 1'b1; memWrite_in = 1'b0; regWrite_in = 1'b1; branchCtrl_in = 1'b0;
      for (int k = 0; k < 20 && !dmem_req_out; k++) begin
         imem_valid_in = imem_req_out;
         @(posedge clk_in); #1;
      end
      imem_valid_in = 1'b0;
      chk("midmem reached", 64'(dmem_req_out), 64'h1);
      @(posedge clk_in); #3;
      reset = 1'b0;
      #1;
      chk("midmem dmem_req", 64'(dmem_req_out), 64'h0);
      chk("midmem imem_req", 64'(imem_req_out), 64'h0);
      chk("midmem pc", pc_out, 64'h0);
      chk("midmem instr", 64'(instr_out), 64'h13);
      chk("midmem strobes", 64'({regWrite_out, retire_out, trap_out, trapCause_out}), 64'h0);
      @(posedge clk_in); #1;
      reset = 1'b1;
      @(posedge clk_in); #1;
      chk("post rst imem_req", 64'(imem_req_out), 64'h1);
      chk("post rst addr", imem_addr_out, 64'h0);
      chk("post rst dmem_req", 64'(dmem_req_out), 64'h0);
      model_pc = '0;
      trapped_last = 1'b0;

      // Random instruction stream against the model, with stray valids.
      stray_en = 1'b1;
      for (int n = 0; n < 60; n++) begin
         int kind = int'($urandom_range(3));
         logic [63:0] t = {$urandom(), $urandom()};
         t[1:0] = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
         v.idly = ($urandom_range(9) == 0) ? TO : int'($urandom_range(3));
         v.ddly = ($urandom_range(9) == 0) ? TO : int'($urandom_range(3));
         v.rd   = (kind == 1);
         v.wr   = (kind == 2) || (kind == 1 && $urandom_range(3) == 0);
         v.rw   = (kind != 2) && ($urandom_range(1) == 1);
         v.br   = (kind == 3) || ($urandom_range(7) == 0);
         v.zf   = ($urandom_range(1) == 1);
         v.ill  = ($urandom_range(15) == 0);
         v.tgt  = t;
         if (trapped_last) begin
            poke_trap(int'(trapCause_out));
            do_reset(1'b0);
         end
         model(v, model_pc);
         run_instr(v, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle instruction sequencer for the RISC-V core; the next generation of the single-cycle top level. It owns the program counter and instruction register, and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. Instruction and data memories are reached through request/valid handshakes with variable latency, and a wait timeout traps a stalled memory. It sits between the memories and the existing decoder, control unit, register file and ALU, and gates their side effects.

## Interface
Parameters:
- REG_DATA_WIDTH_POW, 6, log2 of the datapath width W; W = 1 << REG_DATA_WIDTH_POW (64 by default).
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.
- MEM_TIMEOUT, 255, maximum wait cycles for a memory response before trapping; valid range is 1 to 65535.

Ports:
- clk_in  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req_out  out  1  instruction fetch request, held high until the response arrives.
- imem_addr_out  out  W  fetch address; equals pc_out.
- imem_valid_in  in  1  instruction response valid.
- imem_instr_in  in  32  fetched instruction.
- instr_out  out  32  instruction register, feeding the decoder.
- pc_out  out  W  current PC.
- illegal_in  in  1  control unit flags an unsupported opcode.
- memRead_in, memWrite_in, regWrite_in, branchCtrl_in  in  1 each  control unit outputs.
- zeroFlag_in  in  1  ALU zero flag.
- branchTarget_in  in  W  branch target, computed externally.
- dmem_req_out  out  1  data memory request.
- dmem_we_out  out  1  write enable for the data request.
- dmem_valid_in  in  1  data response or write acknowledge.
- regWrite_out  out  1  register-file write strobe, one cycle long.
- retire_out  out  1  one-cycle pulse for each completed instruction.
- trap_out  out  1  sticky trap indicator.
- trapCause_out  out  2  trap cause code.

## Operation
- States: RESET_S, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- RESET_S is entered only on reset and always moves to FETCH.
- FETCH:
  - imem_req_out = 1.
  - When imem_valid_in = 1: capture imem_instr_in into instr_out and go to DECODE.
- DECODE:
  - If illegal_in = 1, go to TRAP with cause ILLEGAL.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - If memRead_in or memWrite_in is set, go to MEM.
  - Otherwise go to WRITEBACK.
- MEM:
  - dmem_req_out = 1 and dmem_we_out = memWrite_in.
  - If both memRead_in and memWrite_in are set, the access is a write.
  - When dmem_valid_in = 1, go to WRITEBACK.
- WRITEBACK:
  - regWrite_out = regWrite_in and retire_out = 1.
  - If branchCtrl_in and zeroFlag_in are both set:
    - If branchTarget_in[1:0] ≠ 0, go to TRAP with cause MISALIGNED; retire_out = 0, regWrite_out = 0, PC unchanged.
    - Otherwise pc_out takes branchTarget_in.
  - If not taken, pc_out takes pc_out + 4, wrapping modulo 2^W.
  - Go to FETCH.
- Wait timer:
  - Counts cycles spent in FETCH or MEM without a valid response; it clears on every state entry.
  - If the count reaches MEM_TIMEOUT, go to TRAP with cause TIMEOUT.
  - A valid response in the same cycle as the count reaching the limit wins; no trap is taken.
- TRAP:
  - Absorbing; only reset exits it.
  - trap_out = 1, and trapCause_out holds the cause.
  - All request outputs and strobes are 0.
- Valid inputs that arrive while the matching request is low are ignored.
- Reset during any state:
  - Any outstanding request is abandoned immediately.
  - The memories must tolerate a request that drops without a response.
- Trap causes: NONE = 0, ILLEGAL = 1, MISALIGNED = 2, TIMEOUT = 3.

## Timing
- Reset values:
  - pc_out = RESET_PC and instr_out = 32'h0000_0013 (NOP).
  - All request outputs, strobes, retire_out and trap_out are 0; trapCause_out = NONE.
- Response timing: a zero-wait memory may assert valid in the same cycle its request first rises.
- Instruction latency with zero-wait memories, counted from entering FETCH:
  - ALU or branch instruction: 4 cycles.
  - Load or store: 5 cycles.
  - Each memory wait cycle adds 1.
- Register outputs: all outputs except the combinational request/strobe decodes are registered.
- Request outputs:
  - imem_req_out, dmem_req_out and dmem_we_out are Moore decodes of the state register.
  - imem_addr_out and dmem_we_out are stable while the request is high.
- PC and instr_out: pc_out updates on the clock edge leaving WRITEBACK. instr_out holds from DECODE through WRITEBACK.
- Control inputs: these derive from instr_out, so they must be stable from DECODE through WRITEBACK.

## Structure
- Package additions to ControlSignals:
  - seqState_t enum.
  - trapCause_t enum (2 bits).
  - NOP_INSTR constant.
- Sub-module wait_timer:
  - A saturating counter with clear and enable inputs and a `hit` output.
  - Its width is $clog2(MEM_TIMEOUT+1).
- Top-level integration:
  - riscv_top replaces ProgramCounter with this block.
  - riscv_top gates RegFile writes with regWrite_out.
  - riscv_top drives DataMemory enables from dmem_req_out and dmem_we_out.

## Test plan
- Reset with pc_out = 0, then three ADDI fetches with zero-wait memory → retire_out pulses on cycles 4, 8 and 12, and pc_out steps 0 → 4 → 8 → C.
- Load with dmem_valid_in delayed by 3 cycles → retire_out on cycle 8 with regWrite_out high for exactly 1 cycle, and dmem_req_out held high for 4 cycles.
- Taken branch with branchTarget_in = 0x40 → next imem_addr_out = 0x40. Target 0x42 → trap_out = 1, trapCause_out = 2, no retire.
- Run with MEM_TIMEOUT = 4 and imem_valid_in never asserted → trap_out rises after exactly 4 FETCH cycles with cause 3, and imem_req_out drops.
- illegal_in asserted in DECODE → TRAP with cause 1; later valid pulses have no effect.
- Assert reset low mid-MEM, then release → all outputs return to reset values, and the first request is an imem fetch of RESET_PC.
